// File: rtl/wptr_full_prog_pkg.sv
// rtl/wptr_full_prog_pkg.sv - shared Gray/binary helpers and depth helper for the FIFO pointer blocks
// Helpers take zero-extended values up to MAX_W bits, so they serve any pointer width.
package wptr_pkg;

  localparam int MAX_W = 32;

  function automatic int unsigned depth_of(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_prog_if.sv
// rtl/wptr_full_prog_if.sv - FIFO write-port bundle between the writer and the write pointer block
// wovf_cnt exists only when WPTR_OVF_CNT_EN is defined.
interface wptr_full_prog_if #(
  parameter int ADDRSIZE  = 8,
  parameter int OVF_CNT_W = 8
);

  logic                winc;
  logic [ADDRSIZE-1:0] waddr;
  logic                wfull;
  logic                wfull_almost;
  logic [ADDRSIZE:0]   wlevel;
  logic                fifo_error_w;
  logic                wovf;
`ifdef WPTR_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] wovf_cnt;
`endif

  if (ADDRSIZE < 2 || OVF_CNT_W < 1) begin : g_param_check
    $error("wptr_full_prog_if: ADDRSIZE must be >= 2 and OVF_CNT_W >= 1");
  end

`ifdef WPTR_OVF_CNT_EN
  modport master (
    output winc,
    input  waddr, wfull, wfull_almost, wlevel, fifo_error_w, wovf, wovf_cnt
  );
  modport slave (
    input  winc,
    output waddr, wfull, wfull_almost, wlevel, fifo_error_w, wovf, wovf_cnt
  );
`else
  modport master (
    output winc,
    input  waddr, wfull, wfull_almost, wlevel, fifo_error_w, wovf
  );
  modport slave (
    input  winc,
    output waddr, wfull, wfull_almost, wlevel, fifo_error_w, wovf
  );
`endif

endinterface

// File: rtl/wptr_full_prog_gray2bin.sv
// rtl/wptr_full_prog_gray2bin.sv - combinational Gray-to-binary decoder, shared by both pointer domains
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/wptr_full_prog.sv
// rtl/wptr_full_prog.sv - write pointer with registered full, programmable almost-full, level and overflow
// Saturating overflow counter present only when WPTR_OVF_CNT_EN is defined.
module wptr_full_prog
  import wptr_pkg::*;
#(
  parameter int ADDRSIZE  = 8,
  parameter int OVF_CNT_W = 8
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic [ADDRSIZE:0] wq2_rptr,
  input  logic [ADDRSIZE:0] af_margin,
  output logic [ADDRSIZE:0] wptr,
  wptr_full_prog_if.slave   wif
);

  localparam logic [ADDRSIZE:0] DEPTH_V = (ADDRSIZE+1)'(depth_of(ADDRSIZE));

  if (ADDRSIZE < 2 || OVF_CNT_W < 1) begin : g_param_check
    $error("wptr_full_prog: ADDRSIZE must be >= 2 and OVF_CNT_W >= 1");
  end

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] lvlnext;
  logic [ADDRSIZE:0] free_next;
  logic              wpush;
  logic              wfull_val;
  logic              waf_val;
  logic              wfull_r;
  logic              waf_r;
  logic [ADDRSIZE:0] wlevel_r;
  logic              wovf_r;
  logic              ovf_event;

  gray2bin #(.W(ADDRSIZE + 1)) u_rptr_decode (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign wpush     = wif.winc & ~wfull_r;
  assign ovf_event = wif.winc & wfull_r;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wpush};
  assign wgraynext = (ADDRSIZE+1)'(bin2gray(MAX_W'(wbinnext)));

  // Modulo subtraction keeps the level correct across pointer wrap.
  assign lvlnext   = wbinnext - rbin;
  assign free_next = DEPTH_V - lvlnext;
  assign wfull_val = (lvlnext == DEPTH_V);
  assign waf_val   = (free_next <= af_margin);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin     <= '0;
      wptr     <= '0;
      wfull_r  <= 1'b0;
      waf_r    <= 1'b0;
      wlevel_r <= '0;
      wovf_r   <= 1'b0;
    end else begin
      wbin     <= wbinnext;
      wptr     <= wgraynext;
      wfull_r  <= wfull_val;
      waf_r    <= waf_val;
      wlevel_r <= lvlnext;
      if (ovf_event) begin
        wovf_r <= 1'b1;
      end
    end
  end

`ifdef WPTR_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_r;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      ovf_cnt_r <= '0;
    end else if (ovf_event && (ovf_cnt_r != {OVF_CNT_W{1'b1}})) begin
      ovf_cnt_r <= ovf_cnt_r + 1'b1;
    end
  end

  assign wif.wovf_cnt = ovf_cnt_r;
`endif

  assign wif.waddr        = wbin[ADDRSIZE-1:0];
  assign wif.wfull        = wfull_r;
  assign wif.wfull_almost = waf_r;
  assign wif.wlevel       = wlevel_r;
  assign wif.fifo_error_w = ovf_event;
  assign wif.wovf         = wovf_r;

endmodule
